// File: rtl/frmbuf_arb_mc.sv
// Round-robin arbiter that grants one frame-buffer channel at a time access to the
// DDR3 MIG native app interface, with a per-grant command limit and forced release.
module frmbuf_arb_mc #(
  parameter int P_CH_NUM    = 4,
  parameter int P_ADDR_W    = 27,
  parameter int P_DATA_W    = 256,
  parameter int P_BURST_MAX = 64
) (
  input  logic                           i_ddr3_clk,
  input  logic                           i_rst,
  input  logic                           i_system_init,
  input  logic [P_CH_NUM-1:0]            i_request,
  output logic [P_CH_NUM-1:0]            o_response,
  input  logic [P_CH_NUM-1:0]            i_bust_end,
  input  logic [P_CH_NUM-1:0]            i_cmd_valid,
  input  logic [3*P_CH_NUM-1:0]          i_rdwr_cmd,
  input  logic [P_ADDR_W*P_CH_NUM-1:0]   i_req_addr,
  input  logic [P_CH_NUM-1:0]            i_wr_en,
  input  logic [P_DATA_W*P_CH_NUM-1:0]   i_wr_data,
  input  logic                           i_app_rdy,
  input  logic                           i_app_wdf_rdy,
  output logic [P_CH_NUM-1:0]            o_cmd_ack,
  output logic [P_CH_NUM-1:0]            o_wdf_ack,
  output logic                           o_app_en,
  output logic [2:0]                     o_app_cmd,
  output logic [P_ADDR_W-1:0]            o_app_addr,
  output logic [P_DATA_W-1:0]            o_app_wdf_data,
  output logic                           o_app_wdf_wren,
  output logic [$clog2(P_CH_NUM)-1:0]    o_grant_id,
  output logic                           o_busy,
  output logic                           o_timeout
);

  localparam int ID_W = $clog2(P_CH_NUM);

  typedef enum logic [1:0] {IDLE, GRANT, BUSY, RELEASE} state_t;

  state_t              state_reg, state_next;
  logic [ID_W-1:0]     rr_ptr_reg;
  logic [ID_W-1:0]     g_reg;
  logic [7:0]          cnt_reg;
  logic                timeout_reg, timeout_next;

  logic [2:0]          cmd_arr  [P_CH_NUM];
  logic [P_ADDR_W-1:0] addr_arr [P_CH_NUM];
  logic [P_DATA_W-1:0] data_arr [P_CH_NUM];

  logic                mig_open;
  logic                cmd_ack_any;
  logic                burst_hit;
  logic                bust_end_g;
  logic                pick_found;
  logic [ID_W-1:0]     pick_idx;
  logic [2*P_CH_NUM-1:0] req2;
  logic [P_CH_NUM-1:0] req_rot;

  // Per-channel bus slices and one-hot status/handshake outputs.
  for (genvar gi = 0; gi < P_CH_NUM; gi++) begin : g_chan
    assign cmd_arr[gi]    = i_rdwr_cmd[gi*3 +: 3];
    assign addr_arr[gi]   = i_req_addr[gi*P_ADDR_W +: P_ADDR_W];
    assign data_arr[gi]   = i_wr_data[gi*P_DATA_W +: P_DATA_W];
    assign o_response[gi] = (state_reg == GRANT) && i_system_init && (g_reg == ID_W'(gi));
    assign o_cmd_ack[gi]  = mig_open && (g_reg == ID_W'(gi)) && i_cmd_valid[gi] && i_app_rdy;
    assign o_wdf_ack[gi]  = mig_open && (g_reg == ID_W'(gi)) && i_wr_en[gi] && i_app_wdf_rdy;
  end

  assign mig_open       = (state_reg == BUSY) && i_system_init;
  assign o_app_en       = mig_open && i_cmd_valid[g_reg];
  assign o_app_cmd      = mig_open ? cmd_arr[g_reg]  : 3'b000;
  assign o_app_addr     = mig_open ? addr_arr[g_reg] : '0;
  assign o_app_wdf_data = mig_open ? data_arr[g_reg] : '0;
  assign o_app_wdf_wren = mig_open && i_wr_en[g_reg];

  assign cmd_ack_any = o_app_en && i_app_rdy;
  assign burst_hit   = cmd_ack_any && (cnt_reg == 8'(P_BURST_MAX - 1));
  assign bust_end_g  = i_bust_end[g_reg];

  assign o_grant_id = g_reg;
  assign o_busy     = (state_reg != IDLE);
  assign o_timeout  = timeout_reg;

  // Rotate requests so bit 0 is the channel right after the last grant.
  assign req2    = {i_request, i_request};
  assign req_rot = P_CH_NUM'(req2 >> (int'(rr_ptr_reg) + 1));

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = P_CH_NUM - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        pick_found = 1'b1;
        pick_idx   = ID_W'((int'(rr_ptr_reg) + 1 + k) % P_CH_NUM);
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    timeout_next = 1'b0;
    if (!i_system_init) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (pick_found) state_next = GRANT;
        GRANT:   state_next = BUSY;
        BUSY: begin
          if (bust_end_g || burst_hit) state_next = RELEASE;
          timeout_next = burst_hit && !bust_end_g;
        end
        RELEASE: state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_ddr3_clk) begin
    if (i_rst) begin
      state_reg   <= IDLE;
      rr_ptr_reg  <= ID_W'(P_CH_NUM - 1);
      g_reg       <= '0;
      cnt_reg     <= 8'd0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      timeout_reg <= timeout_next;
      if (state_reg == IDLE && i_system_init && pick_found)
        g_reg <= pick_idx;
      // A dropped calibration abandons the grant, so the next owner starts a fresh count.
      if (state_reg == RELEASE || !i_system_init)
        cnt_reg <= 8'd0;
      else if (cmd_ack_any)
        cnt_reg <= cnt_reg + 8'd1;
      if (state_reg == RELEASE && i_system_init)
        rr_ptr_reg <= g_reg;
    end
  end

endmodule

// File: tb/tb_frmbuf_arb_mc.sv
// Directed bench for frmbuf_arb_mc: grant latency, round-robin order, forced release,
// MIG back-pressure, coincident bust_end, calibration gating and mid-burst reset.
module tb_frmbuf_arb_mc;

  localparam int CH = 4;
  localparam int AW = 27;
  localparam int DW = 256;

  logic              clk = 1'b0;
  logic              srst;
  logic              init;
  logic [CH-1:0]     request, response, bust_end, cmd_valid, wr_en, cmd_ack, wdf_ack;
  logic [3*CH-1:0]   rdwr_cmd;
  logic [AW*CH-1:0]  req_addr;
  logic [DW*CH-1:0]  wr_data;
  logic              app_rdy, wdf_rdy;
  logic              app_en, wdf_wren, busy, timeout;
  logic [2:0]        app_cmd;
  logic [AW-1:0]     app_addr;
  logic [DW-1:0]     wdf_data;
  logic [1:0]        grant_id;

  int n_checks = 0;
  int n_fail   = 0;
  int acks;

  always #5 clk = ~clk;

  frmbuf_arb_mc #(.P_CH_NUM(CH), .P_ADDR_W(AW), .P_DATA_W(DW), .P_BURST_MAX(64)) dut (
    .i_ddr3_clk(clk), .i_rst(srst), .i_system_init(init),
    .i_request(request), .o_response(response), .i_bust_end(bust_end),
    .i_cmd_valid(cmd_valid), .i_rdwr_cmd(rdwr_cmd), .i_req_addr(req_addr),
    .i_wr_en(wr_en), .i_wr_data(wr_data), .i_app_rdy(app_rdy), .i_app_wdf_rdy(wdf_rdy),
    .o_cmd_ack(cmd_ack), .o_wdf_ack(wdf_ack), .o_app_en(app_en), .o_app_cmd(app_cmd),
    .o_app_addr(app_addr), .o_app_wdf_data(wdf_data), .o_app_wdf_wren(wdf_wren),
    .o_grant_id(grant_id), .o_busy(busy), .o_timeout(timeout)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full grant from IDLE: GRANT, n acked commands ending with bust_end, RELEASE, IDLE.
  task automatic serve(input int ch, input int n);
    tick;
    chk("rr_response", 64'(response), 64'(1) << ch);
    chk("rr_grant_id", 64'(grant_id), 64'(ch));
    for (int k = 0; k < n; k++) begin
      tick;
      if (k == n - 1) bust_end = CH'(1 << ch);
      #1;
      chk("rr_cmd_ack", 64'(cmd_ack), 64'(1) << ch);
    end
    tick;
    bust_end = '0;
    #1;
    chk("rr_release_en", 64'(app_en), 64'(0));
    tick;
    chk("rr_idle_busy", 64'(busy), 64'(0));
  endtask

  initial begin
    srst = 1'b1; init = 1'b0; request = '0; bust_end = '0; cmd_valid = '0; wr_en = '0;
    app_rdy = 1'b1; wdf_rdy = 1'b1;
    for (int c = 0; c < CH; c++) begin
      rdwr_cmd[c*3 +: 3]   = (c % 2 == 0) ? 3'b001 : 3'b000;
      req_addr[c*AW +: AW] = AW'(32'h1000 * (c + 1));
      wr_data[c*DW +: DW]  = {4{64'hA5A5_0000_0000_0000 + 64'(c)}};
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_response", 64'(response), 64'(0));
    chk("rst_app_en", 64'(app_en), 64'(0));
    chk("rst_timeout", 64'(timeout), 64'(0));
    chk("rst_grant_id", 64'(grant_id), 64'(0));
    srst = 1'b0;

    // 1: single requester latency
    init = 1'b1; request = 4'b0001; cmd_valid = 4'b0001;
    #1;
    chk("t1_resp_n", 64'(response), 64'(0));
    tick;
    chk("t1_resp_n1", 64'(response), 64'h1);
    chk("t1_en_n1", 64'(app_en), 64'(0));
    tick;
    chk("t1_en_n2", 64'(app_en), 64'(1));
    chk("t1_addr", 64'(app_addr), 64'h1000);
    chk("t1_ack", 64'(cmd_ack), 64'h1);
    cmd_valid = '0;
    #1;
    chk("t1_en_follow", 64'(app_en), 64'(0));
    bust_end = 4'b0001; request = '0;
    tick;
    bust_end = '0;
    #1;
    chk("t1_release_busy", 64'(busy), 64'(1));
    tick;
    chk("t1_idle_busy", 64'(busy), 64'(0));

    // 2: round robin from reset, two acks per grant
    srst = 1'b1;
    tick;
    srst = 1'b0;
    request = 4'hF; cmd_valid = 4'hF;
    serve(0, 2);
    serve(1, 2);
    serve(2, 2);
    serve(3, 2);
    serve(0, 2);

    // 3: ch2 hits the burst limit, ch3 follows
    request = 4'b1100; cmd_valid = 4'b0100;
    tick;
    chk("t3_resp", 64'(response), 64'h4);
    acks = 0;
    repeat (64) begin
      tick;
      if (cmd_ack == 4'b0100) acks++;
    end
    tick;
    chk("t3_ack_total", 64'(acks), 64'd64);
    chk("t3_timeout", 64'(timeout), 64'(1));
    chk("t3_release_ack", 64'(cmd_ack), 64'(0));
    tick;
    chk("t3_timeout_pulse", 64'(timeout), 64'(0));
    tick;
    chk("t3_next_ch3", 64'(response), 64'h8);
    request = '0; cmd_valid = '0;
    tick;
    bust_end = 4'b1000;
    #1;
    tick;
    bust_end = '0;
    #1;
    chk("t3_bust_end_no_timeout", 64'(timeout), 64'(0));
    tick;

    // 4: MIG back-pressure, write beats independent of command acceptance
    request = 4'b0001; cmd_valid = 4'b0001; wr_en = 4'b0001; app_rdy = 1'b0;
    tick;
    chk("t4_resp", 64'(response), 64'h1);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("t4_hold_en", 64'(app_en), 64'(1));
      chk("t4_hold_addr", 64'(app_addr), 64'h1000);
      chk("t4_hold_cmd", 64'(app_cmd), 64'h1);
      chk("t4_no_ack", 64'(cmd_ack), 64'(0));
      chk("t4_wdf_ack", 64'(wdf_ack), 64'h1);
    end
    chk("t4_wdf_data", wdf_data[63:0], 64'hA5A5_0000_0000_0000);
    tick;
    app_rdy = 1'b1;
    #1;
    chk("t4_ack_on_rdy", 64'(cmd_ack), 64'h1);
    wr_en = '0;

    // 5: bust_end coincident with an accepted command
    tick;
    bust_end = 4'b0001;
    #1;
    chk("t5_ack", 64'(cmd_ack), 64'h1);
    tick;
    bust_end = '0;
    #1;
    chk("t5_release_en", 64'(app_en), 64'(0));
    chk("t5_release_ack", 64'(cmd_ack), 64'(0));
    cmd_valid = '0; request = '0;
    tick;
    chk("t5_idle", 64'(busy), 64'(0));

    // 6: calibration gating, reset mid-BUSY, init drop keeps rr pointer
    init = 1'b0; request = 4'hF; cmd_valid = 4'hF;
    tick;
    chk("t6_noinit_resp", 64'(response), 64'(0));
    tick;
    chk("t6_noinit_busy", 64'(busy), 64'(0));
    init = 1'b1;
    tick;
    chk("t6_resp_ch1", 64'(response), 64'h2);
    tick;
    chk("t6_busy_en", 64'(app_en), 64'(1));
    srst = 1'b1;
    tick;
    chk("t6_rst_en", 64'(app_en), 64'(0));
    chk("t6_rst_busy", 64'(busy), 64'(0));
    chk("t6_rst_ack", 64'(cmd_ack), 64'(0));
    chk("t6_rst_gid", 64'(grant_id), 64'(0));
    srst = 1'b0;
    tick;
    chk("t6_after_rst_ch0", 64'(response), 64'h1);
    tick;
    init = 1'b0;
    #1;
    chk("t6_init_drop_en", 64'(app_en), 64'(0));
    tick;
    chk("t6_init_drop_idle", 64'(busy), 64'(0));
    init = 1'b1;
    tick;
    chk("t6_rr_kept_ch0", 64'(response), 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
